// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : two-port (fetch/data) arbiter onto one single-port memory. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int ADDRWIDTH    = 18,
  parameter int DATAWIDTH    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDRWIDTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic [DATAWIDTH-1:0] if_rdata,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [ADDRWIDTH-1:0] dm_addr,
  input  logic [DATAWIDTH-1:0] dm_wdata,
  output logic                 dm_gnt,
  output logic                 dm_valid,
  output logic [DATAWIDTH-1:0] dm_rdata,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_write,
  output logic [DATAWIDTH-1:0] mem_in,
  input  logic [DATAWIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                 state;
  logic [3:0]             starve_cnt;
  logic                   load_pending;
  logic [DATAWIDTH-1:0]   if_hold;
  logic [DATAWIDTH-1:0]   dm_hold;
  logic                   starved;

  assign starved   = (starve_cnt == LIMIT);
  assign if_gnt    = rst & if_req & (~dm_req | starved);
  assign dm_gnt    = rst & dm_req & ~if_gnt;

  assign mem_addr  = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
  assign mem_write = dm_gnt & dm_we;
  assign mem_in    = (if_gnt | dm_gnt) ? dm_wdata : '0;

  assign if_valid  = (state == IF_BUSY);
  assign dm_valid  = (state == DM_BUSY);

  // The synchronous RAM presents read data in the cycle after the grant, so the
  // busy cycle forwards mem_out directly and the hold registers keep it afterwards.
  assign if_rdata  = if_valid ? mem_out : if_hold;
  assign dm_rdata  = (dm_valid && load_pending) ? mem_out : dm_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      starve_cnt   <= 4'd0;
      load_pending <= 1'b0;
      if_hold      <= '0;
      dm_hold      <= '0;
    end else begin
      case (state)
        IF_BUSY: if_hold <= mem_out;
        DM_BUSY: if (load_pending) dm_hold <= mem_out;
        default: ;
      endcase

      if (if_gnt)      state <= IF_BUSY;
      else if (dm_gnt) state <= DM_BUSY;
      else             state <= IDLE;

      load_pending <= dm_gnt & ~dm_we;

      if (!if_req || if_gnt)    starve_cnt <= 4'd0;
      else if (!starved)        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [17:0] if_addr, dm_addr;
  logic [31:0] dm_wdata;
  logic        if_gnt, if_valid, dm_gnt, dm_valid, mem_write;
  logic [31:0] if_rdata, dm_rdata, mem_in;
  logic [31:0] mem_out = 32'd0;
  logic [17:0] mem_addr;
  logic [31:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.ADDRWIDTH(18), .DATAWIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_in(mem_in),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_in;
    mem_out <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_mutex", 32'(if_gnt & dm_gnt), 32'd0);
      chk("valid_mutex", 32'(if_valid & dm_valid), 32'd0);
      chk("memwr_implies", 32'(mem_write & ~(dm_gnt & dm_we)), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 32'h2402000A;
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;

    // Reset state, with both requests active during reset
    tick();
    if_req = 1'b1; if_addr = 18'h10; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 18'h7;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Fetch only
    tick();
    if_req = 1'b1; if_addr = 18'h10;
    #1;
    chk("fetch_if_gnt", 32'(if_gnt), 32'd1);
    chk("fetch_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h10);
    chk("fetch_mem_write", 32'(mem_write), 32'd0);
    tick();
    if_req = 1'b0;
    #1;
    chk("fetch_if_valid", 32'(if_valid), 32'd1);
    chk("fetch_if_rdata", if_rdata, 32'h2402000A);
    chk("fetch_dm_valid", 32'(dm_valid), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);
    chk("idle_mem_in", mem_in, 32'd0);
    tick(); #1;
    chk("fetch_valid_drop", 32'(if_valid), 32'd0);
    chk("fetch_rdata_hold", if_rdata, 32'h2402000A);

    // Store then load
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 18'h5; dm_wdata = 32'hDEADBEEF;
    #1;
    chk("store_dm_gnt", 32'(dm_gnt), 32'd1);
    chk("store_mem_write", 32'(mem_write), 32'd1);
    chk("store_mem_addr", 32'(mem_addr), 32'h5);
    chk("store_mem_in", mem_in, 32'hDEADBEEF);
    tick();
    dm_we = 1'b0;
    #1;
    chk("load_dm_gnt", 32'(dm_gnt), 32'd1);
    chk("load_mem_write", 32'(mem_write), 32'd0);
    chk("store_dm_valid", 32'(dm_valid), 32'd1);
    chk("store_rdata_same", dm_rdata, 32'd0);
    tick();
    dm_req = 1'b0;
    #1;
    chk("load_dm_valid", 32'(dm_valid), 32'd1);
    chk("load_dm_rdata", dm_rdata, 32'hDEADBEEF);
    tick(); #1;
    chk("load_valid_drop", 32'(dm_valid), 32'd0);
    chk("load_rdata_hold", dm_rdata, 32'hDEADBEEF);

    // Contention: four data grants, then the starved fetch wins, repeating
    tick();
    if_req = 1'b1; if_addr = 18'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 18'h5;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont_if_gnt_%0d", i), 32'(if_gnt), 32'((i % 5) == 4));
      chk($sformatf("cont_dm_gnt_%0d", i), 32'(dm_gnt), 32'((i % 5) != 4));
      if (i > 0) begin
        chk($sformatf("cont_if_valid_%0d", i), 32'(if_valid), 32'(((i - 1) % 5) == 4));
        chk($sformatf("cont_dm_valid_%0d", i), 32'(dm_valid), 32'(((i - 1) % 5) != 4));
      end
      tick();
    end
    #1;
    chk("cont_last_if_valid", 32'(if_valid), 32'd1);
    chk("cont_last_if_rdata", if_rdata, 32'h2402000A);
    chk("cont_dm_rdata", dm_rdata, 32'hDEADBEEF);

    // Dropped fetch request clears the starvation count
    tick();                         // counter already 0 after the fetch grant
    tick();                         // two denied cycles -> count 2
    if_req = 1'b0;
    #1;
    chk("drop_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    if_req = 1'b1;
    #1;
    chk("drop_no_if_valid", 32'(if_valid), 32'd0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) #1;
      chk($sformatf("refill_if_gnt_%0d", j), 32'(if_gnt), 32'(j == 4));
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Back-to-back alternating sole requesters
    tick();
    for (int k = 0; k < 6; k++) begin
      if_req = ((k % 2) == 0);
      dm_req = ((k % 2) == 1);
      #1;
      chk($sformatf("alt_if_gnt_%0d", k), 32'(if_gnt), 32'((k % 2) == 0));
      chk($sformatf("alt_dm_gnt_%0d", k), 32'(dm_gnt), 32'((k % 2) == 1));
      if (k > 0) begin
        chk($sformatf("alt_if_valid_%0d", k), 32'(if_valid), 32'((k % 2) == 1));
        chk($sformatf("alt_dm_valid_%0d", k), 32'(dm_valid), 32'((k % 2) == 0));
      end
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    #1;
    chk("alt_last_dm_valid", 32'(dm_valid), 32'd1);
    tick();

    // Reset while a load is in flight
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 18'h10;
    #1;
    chk("rmid_dm_gnt", 32'(dm_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; dm_req = 1'b0;
    #1;
    chk("rmid_dm_valid", 32'(dm_valid), 32'd0);
    chk("rmid_dm_rdata", dm_rdata, 32'd0);
    chk("rmid_if_rdata", if_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 18'h5;
    #1;
    chk("rpost_dm_valid", 32'(dm_valid), 32'd0);
    chk("rpost_first_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    #1;
    chk("rpost_if_rdata", if_rdata, 32'hDEADBEEF);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
